// File: rtl/parking_slot_ctrl.sv
// parking_slot_ctrl
// Central sequencer for the parking lot. It arbitrates the entry and exit
// gate requests, with exit winning over entry. It allocates free slots
// lowest-number-first and stores a check-in timestamp for every slot. On
// exit it reports how long the car stayed. After every accepted
// transaction it opens the gate for a fixed number of cycles.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   timer_i        free-running time base, sampled on the serve edge
//   entry_req_i    car waiting at the entry gate (held until ack/rej)
//   exit_req_i     car waiting at the exit gate (held until ack/err)
//   exit_slot_i    slot being vacated, valid while exit_req_i is high
//   entry_ack_o    one-cycle pulse, slot granted
//   entry_slot_o   granted slot number, held until the next grant
//   entry_rej_o    one-cycle pulse, lot full
//   exit_ack_o     one-cycle pulse, slot released
//   exit_err_o     one-cycle pulse, bad or empty slot on exit
//   duration_o     elapsed time of the released slot, held until next exit
//   occupancy_o    bit i-1 set means slot i is occupied
//   free_count_o   number of unoccupied slots
//   full_o         every slot occupied
//   gate_open_o    gate actuation strobe
module parking_slot_ctrl #(
   parameter int NUM_SLOTS   = 6,
   parameter int TIME_W      = 11,
   parameter int GATE_CYCLES = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [TIME_W-1:0]    timer_i,
   input  logic                 entry_req_i,
   input  logic                 exit_req_i,
   input  logic [2:0]           exit_slot_i,
   output logic                 entry_ack_o,
   output logic [2:0]           entry_slot_o,
   output logic                 entry_rej_o,
   output logic                 exit_ack_o,
   output logic                 exit_err_o,
   output logic [TIME_W-1:0]    duration_o,
   output logic [NUM_SLOTS-1:0] occupancy_o,
   output logic [2:0]           free_count_o,
   output logic                 full_o,
   output logic                 gate_open_o
);

   // The gate counter holds the number of gate cycles still to come after
   // the current one. It therefore never needs to reach GATE_CYCLES itself.
   localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_EXIT,
      SERVE_ENTRY,
      GATE
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       gateCnt_q, gateCnt_d;
   logic                   entryAck_q, entryAck_d;
   logic [2:0]             entrySlot_q, entrySlot_d;
   logic                   entryRej_q, entryRej_d;
   logic                   exitAck_q, exitAck_d;
   logic                   exitErr_q, exitErr_d;
   logic [TIME_W-1:0]      duration_q, duration_d;
   logic [NUM_SLOTS-1:0]   occupancy_q, occupancy_d;
   logic [2:0]             freeCount_q, freeCount_d;
   logic                   full_q, full_d;
   logic                   gateOpen_q, gateOpen_d;
   logic [TIME_W-1:0]      stamp_q [NUM_SLOTS];

   logic [NUM_SLOTS-1:0]   freeOneHot;
   logic [2:0]             freeSlot;
   logic [NUM_SLOTS-1:0]   exitMask;
   logic                   exitOk;
   logic [TIME_W-1:0]      stampSel;
   logic [NUM_SLOTS-1:0]   stampWe;
   int                     occCount;

   // Slot lookup helpers. ~occ & (occ + 1) isolates the lowest clear bit.
   // That bit is the lowest-numbered free slot. The exit mask decodes the
   // requested slot number into a one-hot vector. Slot numbers 0 and
   // values above NUM_SLOTS give an all-zero mask, so they can never match
   // an occupied bit. Only a valid, occupied slot sets exitOk.
   always_comb begin
      freeOneHot = ~occupancy_q & (occupancy_q + 1'b1);
      freeSlot   = 3'd0;
      exitMask   = '0;
      stampSel   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (freeOneHot[i]) begin
            freeSlot = 3'(i + 1);
         end
         if (exit_slot_i == 3'(i + 1)) begin
            exitMask[i] = 1'b1;
            stampSel    = stamp_q[i];
         end
      end
      exitOk = |(exitMask & occupancy_q);
   end

   // Next-state and next-output logic. All outputs are registered, so this
   // block only decides what each register takes on the coming edge. The
   // ack/rej/err pulses and the gate strobe default to low. The held
   // values (slot, duration, occupancy) default to their current contents.
   always_comb begin
      state_d     = state_q;
      gateCnt_d   = gateCnt_q;
      entryAck_d  = 1'b0;
      entrySlot_d = entrySlot_q;
      entryRej_d  = 1'b0;
      exitAck_d   = 1'b0;
      exitErr_d   = 1'b0;
      duration_d  = duration_q;
      occupancy_d = occupancy_q;
      gateOpen_d  = 1'b0;
      stampWe     = '0;

      case (state_q)
         IDLE: begin
            if (exit_req_i) begin
               state_d = SERVE_EXIT;
            end else if (entry_req_i) begin
               state_d = SERVE_ENTRY;
            end
         end

         SERVE_EXIT: begin
            if (exitOk) begin
               occupancy_d = occupancy_q & ~exitMask;
               duration_d  = timer_i - stampSel;
               exitAck_d   = 1'b1;
               gateOpen_d  = 1'b1;
               gateCnt_d   = CNT_W'(GATE_CYCLES - 1);
               state_d     = GATE;
            end else begin
               exitErr_d = 1'b1;
               state_d   = IDLE;
            end
         end

         SERVE_ENTRY: begin
            if (|freeOneHot) begin
               occupancy_d = occupancy_q | freeOneHot;
               stampWe     = freeOneHot;
               entrySlot_d = freeSlot;
               entryAck_d  = 1'b1;
               gateOpen_d  = 1'b1;
               gateCnt_d   = CNT_W'(GATE_CYCLES - 1);
               state_d     = GATE;
            end else begin
               entryRej_d = 1'b1;
               state_d    = IDLE;
            end
         end

         GATE: begin
            if (gateCnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gateCnt_d  = gateCnt_q - 1'b1;
               gateOpen_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      occCount = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         occCount = occCount + int'(occupancy_d[i]);
      end
      freeCount_d = 3'(NUM_SLOTS - occCount);
      full_d      = &occupancy_d;
   end

   // State, output and timestamp registers. Reset abandons any transaction
   // in flight, so no pulse that was pending is ever issued.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         gateCnt_q    <= '0;
         entryAck_q   <= 1'b0;
         entrySlot_q  <= 3'd0;
         entryRej_q   <= 1'b0;
         exitAck_q    <= 1'b0;
         exitErr_q    <= 1'b0;
         duration_q   <= '0;
         occupancy_q  <= '0;
         freeCount_q  <= 3'(NUM_SLOTS);
         full_q       <= 1'b0;
         gateOpen_q   <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            stamp_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         gateCnt_q    <= gateCnt_d;
         entryAck_q   <= entryAck_d;
         entrySlot_q  <= entrySlot_d;
         entryRej_q   <= entryRej_d;
         exitAck_q    <= exitAck_d;
         exitErr_q    <= exitErr_d;
         duration_q   <= duration_d;
         occupancy_q  <= occupancy_d;
         freeCount_q  <= freeCount_d;
         full_q       <= full_d;
         gateOpen_q   <= gateOpen_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (stampWe[i]) begin
               stamp_q[i] <= timer_i;
            end
         end
      end
   end

   assign entry_ack_o  = entryAck_q;
   assign entry_slot_o = entrySlot_q;
   assign entry_rej_o  = entryRej_q;
   assign exit_ack_o   = exitAck_q;
   assign exit_err_o   = exitErr_q;
   assign duration_o   = duration_q;
   assign occupancy_o  = occupancy_q;
   assign free_count_o = freeCount_q;
   assign full_o       = full_q;
   assign gate_open_o  = gateOpen_q;

endmodule

// File: doc/parking_slot_ctrl.md
Name: parking_slot_ctrl

Overview:
- Central sequencer for the parking lot. Arbitrates entry and exit gate requests and allocates free slots lowest-index-first.
- Stores per-slot check-in timestamps from the shared timer and computes parking duration on exit.
- Drives the gate-open strobe and publishes occupancy status to the display/fee logic.
- Sits between the gate sensors/keypad selector and the fee and display blocks.

Parameters:
- NUM_SLOTS, 6, number of parking slots, numbered 1..NUM_SLOTS.
- TIME_W, 11, width of timer and of the stored timestamps.
- GATE_CYCLES, 4, number of cycles gate_open stays high after each accepted transaction (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- timer  in  TIME_W  free-running time base, sampled as the check-in/check-out time.
- entry_req  in  1  car at entry gate; requester holds it high until entry_ack or entry_rej.
- exit_req  in  1  car at exit gate; requester holds it high until exit_ack or exit_err.
- exit_slot  in  3  slot being vacated, valid while exit_req is high.
- entry_ack  out  1  one-cycle pulse: slot granted.
- entry_slot  out  3  granted slot number; held until the next grant.
- entry_rej  out  1  one-cycle pulse: lot full.
- exit_ack  out  1  one-cycle pulse: slot released.
- exit_err  out  1  one-cycle pulse: exit_slot is out of range (0 or >NUM_SLOTS) or the slot is not occupied.
- duration  out  TIME_W  timer minus check-in time of the released slot; valid with exit_ack and held until the next exit_ack.
- occupancy  out  NUM_SLOTS  bit i-1 set = slot i occupied.
- free_count  out  3  number of unoccupied slots.
- full  out  1  high when occupancy is all ones.
- gate_open  out  1  gate actuation strobe.

Behaviour:
- Reset: state IDLE. All outputs are 0 except free_count = NUM_SLOTS. Timestamp storage is cleared to 0. Reset mid-transaction aborts the transaction, and no ack is issued.
- All outputs are registered.
- FSM states:
  - IDLE: sample requests.
  - SERVE_EXIT
  - SERVE_ENTRY
  - GATE: counter runs GATE_CYCLES cycles.
- IDLE transitions:
  - exit_req high → SERVE_EXIT.
  - Else entry_req high → SERVE_ENTRY.
  - Exit has priority over entry on simultaneous requests.
- SERVE_EXIT, exit_slot valid and occupied:
  - Clear the occupancy bit.
  - duration <= (timer − stamp[slot]) mod 2^TIME_W, so timer wrap-around yields the correct elapsed time when the stay is < 2^TIME_W.
  - Pulse exit_ack, then go to GATE.
- SERVE_EXIT, exit_slot invalid or unoccupied: pulse exit_err, then go to IDLE. No gate, no state change.
- SERVE_ENTRY, not full:
  - Pick the lowest-numbered free slot s.
  - stamp[s] <= timer; set its occupancy bit; entry_slot <= s.
  - Pulse entry_ack, then go to GATE.
- SERVE_ENTRY, full: pulse entry_rej, then go to IDLE.
- Latency: a request seen at clock edge k in IDLE produces its ack/rej/err visible after edge k+1 (exactly one cycle high).
- GATE: gate_open is high for exactly GATE_CYCLES cycles, starting the same cycle as the ack. The FSM then returns to IDLE.
- Requests are ignored outside IDLE. A held request is served on the first IDLE edge afterwards.
- Status outputs:
  - occupancy, free_count and full update in the same cycle as the ack.
  - free_count always equals NUM_SLOTS minus the popcount of occupancy.
- The timer value used is the one sampled at the SERVE edge.
- A simultaneous exit and entry while full results in the exit being served first; the entry then receives the freed slot.

Test Plan:
- Reset, then 6 sequential entries at timer=10,20,…,60 → entry_slot 1..6 in order; full=1; free_count=0; each ack arrives 2 edges after req; gate_open high for 4 cycles each time.
- 7th entry while full → entry_rej pulse; no gate_open; occupancy stays 6'b111111.
- Exit slot 3 at timer=100 (check-in 30) → exit_ack, duration=70, occupancy=6'b111011; next entry → entry_slot=3.
- Entry at timer=2040, exit of the same slot at timer=5 → duration=13 (wrap).
- Exit slot 0, slot 7, and an empty slot → exit_err each; no gate_open; occupancy unchanged.
- entry_req and exit_req asserted together while full, plus rst asserted during GATE → exit served then entry reuses the slot; rst returns all outputs to reset values within one edge.
